// File: rtl/codeword_packer.sv
// Packs variable-length codewords MSB-first into OUT_W-bit words and queues them
// in a small first-word-fall-through FIFO with frame-end flush and zero padding.
module codeword_packer #(
    parameter int MAX_CW     = 16,
    parameter int LEN_W      = 5,
    parameter int OUT_W      = 16,
    parameter int FILL_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [MAX_CW-1:0] cw_data,
    input  logic [LEN_W-1:0]  cw_len,
    input  logic              cw_last,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [FILL_W-1:0] out_fill
);
    localparam int ACC_W = OUT_W + MAX_CW;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [OUT_W-1:0]  data;
        logic              last;
        logic [FILL_W-1:0] fill;
    } entry_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0]  fill_cnt, fill_nxt;
    logic              live;
    logic [LEN_W-1:0]  len_c;
    logic [MAX_CW-1:0] data_m;
    logic              accept, push, pop, can_push;
    entry_t            push_entry;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              full, empty;
    entry_t            head, hold, shown;

    // Over-long lengths are clamped and bits above the length are dropped.
    assign len_c  = (cw_len > LEN_W'(MAX_CW)) ? LEN_W'(MAX_CW) : cw_len;
    assign data_m = cw_data & ~({MAX_CW{1'b1}} << len_c);

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop      = out_valid && out_ready;
    assign can_push = !full || pop;

    // live holds cw_ready low until the first edge after reset release.
    assign cw_ready = live && (state == RUN) && (fill_cnt < CNT_W'(OUT_W));
    assign accept   = cw_valid && cw_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt  = state;
        acc_nxt    = acc;
        fill_nxt   = fill_cnt;
        push       = 1'b0;
        push_entry = '{data: acc[ACC_W-1 -: OUT_W], last: 1'b0, fill: FILL_W'(OUT_W)};

        if (accept) begin
            acc_nxt  = acc | (ACC_W'(data_m) << (CNT_W'(ACC_W) - fill_cnt - CNT_W'(len_c)));
            fill_nxt = fill_cnt + CNT_W'(len_c);
            if (cw_last) state_nxt = FLUSH;
        end else if (can_push) begin
            if (state == RUN) begin
                if (fill_cnt >= CNT_W'(OUT_W)) begin
                    push     = 1'b1;
                    acc_nxt  = acc << OUT_W;
                    fill_nxt = fill_cnt - CNT_W'(OUT_W);
                end
            end else begin
                push = 1'b1;
                if (fill_cnt > CNT_W'(OUT_W)) begin
                    acc_nxt  = acc << OUT_W;
                    fill_nxt = fill_cnt - CNT_W'(OUT_W);
                end else begin
                    // Bits below fill_cnt are always zero, so the top slice is already padded.
                    push_entry.last = 1'b1;
                    push_entry.fill = FILL_W'(fill_cnt);
                    acc_nxt         = '0;
                    fill_nxt        = '0;
                    state_nxt       = RUN;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= RUN;
            acc      <= '0;
            fill_cnt <= '0;
            live     <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            fill_cnt <= fill_nxt;
            live     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= head;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    // When empty, the outputs keep showing the last word that left (zero after reset).
    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign shown     = empty ? hold : head;
    assign out_valid = !empty;
    assign out_data  = shown.data;
    assign out_last  = shown.last;
    assign out_fill  = shown.fill;
endmodule

// File: tb/tb_codeword_packer.sv
// Directed bench for codeword_packer: a bit-level reference model fills a scoreboard
// as beats are driven, and a monitor compares every word the FIFO hands out.
module tb_codeword_packer;
    logic        clk = 1'b0;
    logic        RST;
    logic        cw_valid;
    logic        cw_ready;
    logic [15:0] cw_data;
    logic [4:0]  cw_len;
    logic        cw_last;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [4:0]  out_fill;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [4:0]  fill;
    } exp_t;

    exp_t sb[$];
    bit   pend[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;

    codeword_packer dut (
        .clk       (clk),
        .RST       (RST),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw_data   (cw_data),
        .cw_len    (cw_len),
        .cw_last   (cw_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_fill  (out_fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic emit(input int k, input logic last);
        logic [15:0] w = '0;
        for (int i = 0; i < k; i++) w[15-i] = pend.pop_front();
        sb.push_back('{data: w, last: last, fill: 5'(k)});
    endtask

    // Reference model: bit-serial queue, words cut on 16-bit boundaries, padded flush at frame end.
    task automatic model_beat(input logic [15:0] d, input int len, input logic last);
        int n = (len > 16) ? 16 : len;
        for (int i = n - 1; i >= 0; i--) pend.push_back(d[i]);
        if (!last) begin
            while (pend.size() >= 16) emit(16, 1'b0);
        end else begin
            while (pend.size() > 16) emit(16, 1'b0);
            emit(pend.size(), 1'b1);
        end
    endtask

    task automatic send(input logic [15:0] d, input int len, input logic last);
        int budget = 200;
        cw_valid = 1'b1;
        cw_data  = d;
        cw_len   = 5'(len);
        cw_last  = last;
        model_beat(d, len, last);
        @(negedge clk);
        while (!cw_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("beat_accept_timeout", cw_ready, 1'b1);
        @(posedge clk);
        #1;
        cw_valid = 1'b0;
        cw_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget = 100;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check({tag, "_words_left"}, sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_no_extra_word"}, out_valid, 1'b0);
    endtask

    // Monitor: a word leaves on the next posedge whenever valid && ready at this negedge.
    always @(negedge clk) begin
        if (RST && out_valid && out_ready) begin
            check("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("word_data", out_data, got.data);
                check("word_last", out_last, got.last);
                check("word_fill", out_fill, got.fill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST       = 1'b0;
        cw_valid  = 1'b0;
        cw_data   = '0;
        cw_len    = '0;
        cw_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_fill", out_fill, 5'd0);
        check("rst_cw_ready", cw_ready, 1'b0);
        RST = 1'b1;
        #1;
        check("release_cw_ready_before_edge", cw_ready, 1'b0);
        @(posedge clk);
        #1;
        check("cw_ready_after_first_edge", cw_ready, 1'b1);

        // Four nibbles make one exactly full final word.
        send(16'h000A, 4, 1'b0);
        send(16'h000B, 4, 1'b0);
        send(16'h000C, 4, 1'b0);
        send(16'h000D, 4, 1'b1);
        check("flush_cw_ready_low", cw_ready, 1'b0);
        @(posedge clk);
        #1;
        check("flush_cw_ready_back", cw_ready, 1'b1);
        check("word_latency_visible", out_valid, 1'b1);
        check("word_abcd_head", out_data, 16'hABCD);
        drain("nibbles");

        // 3'b101 then 2'b01 -> 10101 padded: 0xA800, 5 bits.
        send(16'h0005, 3, 1'b0);
        send(16'h0001, 2, 1'b1);
        drain("partial");

        // Masking of bits above len and clamping of len 31 to 16; frame spans 20 bits.
        send(16'hFFF5, 4, 1'b0);
        send(16'hABCD, 31, 1'b1);
        drain("mask_clamp");

        // Two full words held under backpressure.
        out_ready = 1'b0;
        send(16'h1234, 16, 1'b0);
        send(16'h5678, 16, 1'b1);
        check("two_full_cw_ready_low", cw_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("held_out_valid", out_valid, 1'b1);
        check("held_head_data", out_data, 16'h1234);
        check("held_head_last", out_last, 1'b0);
        out_ready = 1'b1;
        drain("two_full");

        // Empty frame marker.
        send(16'hFFFF, 0, 1'b1);
        drain("empty_frame");

        // Continuous 12-bit beats against a full FIFO: 120 bits -> 7 full words + 8 bits.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(16'h0FFF, 12, i == 9);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                check("fifo_full_cw_ready_low", cw_ready, 1'b0);
                check("fifo_full_out_valid", out_valid, 1'b1);
                out_ready = 1'b1;
            end
        join
        drain("stream12");

        // Reset mid-frame with queued words discards everything.
        out_ready = 1'b0;
        send(16'h1111, 16, 1'b0);
        send(16'h2222, 16, 1'b0);
        send(16'h3333, 16, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("queued_before_reset", out_valid, 1'b1);
        RST = 1'b0;
        #1;
        check("reset_out_valid_immediate", out_valid, 1'b0);
        check("reset_cw_ready_immediate", cw_ready, 1'b0);
        sb.delete();
        pend.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_cw_ready", cw_ready, 1'b1);
        send(16'h00C3, 8, 1'b1);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
